simple_calculator: RTL and testbench
====================================

Name:
simple_calculator

Overview:
- Small arithmetic unit with two-entry result memory and a two-digit decimal seven-segment display.
- Performs add, subtract, multiply or divide on two 3-bit unsigned operands.
- On load, stores the result as "current" and pushes the old current value to "previous".
- `addr` selects which stored value is shown on two seven-segment digits (tens, units).
- Sits at board top level, driven by switches/buttons and driving two displays.

Parameters:
- none. Operand width is fixed at 3 bits; result and memory width is fixed at 6 bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets).
- a  input  3  operand A, unsigned.
- b  input  3  operand B, unsigned.
- op  input  2  operation select: 00 add, 01 sub, 10 mul, 11 div.
- load  input  1  store-result strobe, sampled on clk rising edge.
- addr  input  1  display select: 0 = current (mem[0]), 1 = previous (mem[1]).
- sev_seg_1  output  7  tens digit segments, active-high, bit0=a … bit6=g.
- sev_seg_2  output  7  units digit segments, same encoding.

Behaviour:
- Result computation (combinational, 6-bit unsigned):
  - add: a+b, range 0..14.
  - sub: a-b when a>=b; 0 when a<b (clamped, no wrap).
  - mul: a*b, range 0..49.
  - div: floor(a/b); b=0 gives 0.
- Memory: two 6-bit registers, mem[0] (current) and mem[1] (previous).
- While rst=0, asynchronously mem[0]=0 and mem[1]=0.
- On a rising clk edge with rst=1 and load=1, both registers update in the same edge: mem[1]<=mem[0], mem[0]<=result.
- load=0: memory holds.
- load is level-sensitive: each rising edge with load=1 performs one shift-and-store.
- Display path is combinational from stored values only; a, b and op changes never reach the display until loaded.
  - val = addr ? mem[1] : mem[0].
  - tens = val/10, range 0..4; units = val%10.
  - Each digit is encoded to seven segments.
- Segment encoding, hex over {g..a}: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Any digit >9 shows 00 (blank); unreachable.
- Leading zero is displayed (value 8 shows "08").
- After reset, both outputs are 3F ("00") for either addr.
- rst asserted during a load cycle: reset wins and memory clears immediately.
- addr changing alters the outputs combinationally with no latency.
- Latency: a result is visible on the display right after the load edge (zero extra cycles).

Decomposition:
- Shared package `calc_pkg` holds:
  - op code constants OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11.
  - digit-to-segment constants (SEG_0..SEG_9, SEG_BLANK).
  - result width constant RES_W=6.
- One sub-module `seg7_decoder`: 4-bit digit in, 7-bit active-high segments out. Instantiated twice, for tens and units.
- ALU, memory and binary-to-BCD split stay in the top block.

Test Plan:
- Reset: rst=0 then 1 → mem[0]=mem[1]=0; sev_seg_1=3F, sev_seg_2=3F for addr=0 and addr=1.
- Load sequence, one load edge each:
  - a=5,b=3,op=00 → mem[0]=8, sev_seg_1=3F, sev_seg_2=7F.
  - a=6,b=2,op=01 → mem[0]=4, mem[1]=8.
  - a=3,b=2,op=10 → mem[0]=6, mem[1]=4.
  - a=4,b=1,op=11 → mem[0]=4, mem[1]=6.
- Previous select: after the load sequence, addr=1 → sev_seg_1=3F, sev_seg_2=7D (shows 6); addr=0 → 3F/66 (shows 4).
- Extremes:
  - a=7,b=7,op=10 loaded → 49: sev_seg_1=66, sev_seg_2=6F.
  - a=7,b=7,op=00 → 14: sev_seg_1=06, sev_seg_2=66.
- Corner ops:
  - a=2,b=5,op=01 → 0 (clamp).
  - a=5,b=0,op=11 → 0.
  - Both show 3F/3F.
- Hold and async reset:
  - load=0 with changing a/b/op → display unchanged.
  - Drop rst mid-cycle while load=1 → outputs go to 3F/3F without waiting for clk.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared constants and types for the simple calculator: op codes, segment
// patterns, result width and the binary-to-decimal digit split.
package calc_pkg;

  localparam int RES_W = 6;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } calc_op_e;

  // Active-high segments, bit0 = a ... bit6 = g.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } digits_t;

  // Compare-and-subtract split of a 6-bit value into two decimal digits.
  // The units difference is always 0..9, so a 4-bit result is exact.
  function automatic digits_t bin_to_digits(input logic [RES_W-1:0] val);
    digits_t d;
    logic [RES_W-1:0] base;
    d.tens = 4'd0;
    base   = 6'd0;
    if (val >= 6'd60) begin
      d.tens = 4'd6;
      base   = 6'd60;
    end else if (val >= 6'd50) begin
      d.tens = 4'd5;
      base   = 6'd50;
    end else if (val >= 6'd40) begin
      d.tens = 4'd4;
      base   = 6'd40;
    end else if (val >= 6'd30) begin
      d.tens = 4'd3;
      base   = 6'd30;
    end else if (val >= 6'd20) begin
      d.tens = 4'd2;
      base   = 6'd20;
    end else if (val >= 6'd10) begin
      d.tens = 4'd1;
      base   = 6'd10;
    end
    d.units = 4'(val - base);
    return d;
  endfunction

endpackage

// File: rtl/simple_calculator_if.sv
// Board-side signal bundle for the calculator: operand/op switches, load and
// display-select buttons, and the two seven-segment digit outputs.
interface simple_calculator_if;
  // load is a level strobe: every rising clk edge that sees load=1 performs
  // one shift-and-store; there is no ready/back-pressure, the store always
  // completes on that edge.
  logic [2:0] a;
  logic [2:0] b;
  logic [1:0] op;
  logic       load;
  logic       addr;
  logic [6:0] sev_seg_1;
  logic [6:0] sev_seg_2;

  modport master (
    output a, b, op, load, addr,
    input  sev_seg_1, sev_seg_2
  );

  modport slave (
    input  a, b, op, load, addr,
    output sev_seg_1, sev_seg_2
  );
endinterface

// File: rtl/seg7_decoder.sv
// Decimal digit to active-high seven-segment pattern; out-of-range digits blank.
module seg7_decoder
  import calc_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/simple_calculator.sv
// 3-bit add/sub/mul/div unit with a two-entry result history (current and
// previous) shown as two decimal digits on seven-segment displays.
module simple_calculator
  import calc_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  simple_calculator_if.slave  bus
);

  logic [RES_W-1:0] result;
  logic [RES_W-1:0] mem_cur;
  logic [RES_W-1:0] mem_prev;
  logic [RES_W-1:0] shown;
  logic [RES_W-1:0] a_ext;
  logic [RES_W-1:0] b_ext;
  calc_op_e         op_sel;
  digits_t          digits;

  assign a_ext  = {3'b000, bus.a};
  assign b_ext  = {3'b000, bus.b};
  assign op_sel = calc_op_e'(bus.op);

  // Subtraction clamps at zero rather than wrapping; divide by zero yields zero.
  always_comb begin
    result = '0;
    unique case (op_sel)
      OP_ADD: result = a_ext + b_ext;
      OP_SUB: result = (bus.a >= bus.b) ? (a_ext - b_ext) : '0;
      OP_MUL: result = a_ext * b_ext;
      OP_DIV: result = (bus.b == 3'd0) ? '0 : {3'b000, bus.a / bus.b};
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_cur  <= '0;
      mem_prev <= '0;
    end else if (bus.load) begin
      mem_prev <= mem_cur;
      mem_cur  <= result;
    end
  end

  // Display depends only on stored values, never on the live operands.
  assign shown  = bus.addr ? mem_prev : mem_cur;
  assign digits = bin_to_digits(shown);

  seg7_decoder u_tens (
    .digit (digits.tens),
    .seg   (bus.sev_seg_1)
  );

  seg7_decoder u_units (
    .digit (digits.units),
    .seg   (bus.sev_seg_2)
  );

endmodule

// File: tb/tb_simple_calculator.sv
// Self-checking bench for simple_calculator: directed table plus random loads
// against a history-queue reference model.
module tb_simple_calculator;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  simple_calculator_if bus ();

  simple_calculator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // History of every stored result since the last reset; newest at the back.
  logic [5:0] exp_q[$];

  logic [6:0] seg_tab[10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  task automatic check_eq(input string tag, input logic [13:0] got, input logic [13:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int ref_result(input int a, input int b, input int op);
    case (op)
      0:       return a + b;
      1:       return (a >= b) ? a - b : 0;
      2:       return a * b;
      default: return (b == 0) ? 0 : a / b;
    endcase
  endfunction

  function automatic logic [13:0] expect_disp(input int v);
    return {seg_tab[v / 10], seg_tab[v % 10]};
  endfunction

  function automatic int model_val(input bit sel);
    int n;
    n = exp_q.size();
    if (!sel) return (n > 0) ? int'(exp_q[n-1]) : 0;
    return (n > 1) ? int'(exp_q[n-2]) : 0;
  endfunction

  task automatic drive_load(input int a, input int b, input int op);
    logic [2:0] av;
    logic [2:0] bv;
    logic [1:0] ov;
    av = a[2:0];
    bv = b[2:0];
    ov = op[1:0];
    @(negedge clk);
    bus.a    = av;
    bus.b    = bv;
    bus.op   = ov;
    bus.load = 1'b1;
    @(posedge clk);
    exp_q.push_back(6'(ref_result(a, b, op)));
    #1 bus.load = 1'b0;
  endtask

  task automatic show(input bit sel);
    bus.addr = sel;
    #1;
  endtask

  task automatic check_model(input string tag);
    for (int s = 0; s < 2; s++) begin
      show(s[0]);
      check_eq(tag, {bus.sev_seg_1, bus.sev_seg_2}, expect_disp(model_val(s[0])));
    end
  endtask

  initial begin
    bus.a    = '0;
    bus.b    = '0;
    bus.op   = '0;
    bus.load = 1'b0;
    bus.addr = 1'b0;

    // Reset
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    show(1'b0);
    check_eq("reset_addr0", {bus.sev_seg_1, bus.sev_seg_2}, {7'h3F, 7'h3F});
    show(1'b1);
    check_eq("reset_addr1", {bus.sev_seg_1, bus.sev_seg_2}, {7'h3F, 7'h3F});

    // Directed load sequence
    show(1'b0);
    drive_load(5, 3, 0);
    show(1'b0);
    check_eq("add_5_3", {bus.sev_seg_1, bus.sev_seg_2}, {7'h3F, 7'h7F});
    drive_load(6, 2, 1);
    check_model("sub_6_2");
    drive_load(3, 2, 2);
    check_model("mul_3_2");
    drive_load(4, 1, 3);
    show(1'b1);
    check_eq("prev_is_6", {bus.sev_seg_1, bus.sev_seg_2}, {7'h3F, 7'h7D});
    show(1'b0);
    check_eq("cur_is_4", {bus.sev_seg_1, bus.sev_seg_2}, {7'h3F, 7'h66});

    // Extremes
    drive_load(7, 7, 2);
    show(1'b0);
    check_eq("mul_max_49", {bus.sev_seg_1, bus.sev_seg_2}, {7'h66, 7'h6F});
    drive_load(7, 7, 0);
    show(1'b0);
    check_eq("add_max_14", {bus.sev_seg_1, bus.sev_seg_2}, {7'h06, 7'h66});
    show(1'b1);
    check_eq("prev_49", {bus.sev_seg_1, bus.sev_seg_2}, {7'h66, 7'h6F});

    // Corner ops
    drive_load(2, 5, 1);
    show(1'b0);
    check_eq("sub_clamp", {bus.sev_seg_1, bus.sev_seg_2}, {7'h3F, 7'h3F});
    drive_load(5, 0, 3);
    show(1'b0);
    check_eq("div_by_zero", {bus.sev_seg_1, bus.sev_seg_2}, {7'h3F, 7'h3F});
    show(1'b1);
    check_eq("div_by_zero_prev", {bus.sev_seg_1, bus.sev_seg_2}, {7'h3F, 7'h3F});

    // Random loads against the model
    for (int i = 0; i < 40; i++) begin
      drive_load($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3));
      check_model($sformatf("rand_%0d", i));
    end

    // Hold: operands churn with load low
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.a    = 3'($urandom_range(0, 7));
      bus.b    = 3'($urandom_range(0, 7));
      bus.op   = 2'($urandom_range(0, 3));
      bus.load = 1'b0;
      @(posedge clk);
      #1;
      check_model($sformatf("hold_%0d", i));
    end

    // Ensure a nonzero value is stored before the async reset test
    drive_load(6, 7, 2);
    check_model("pre_reset_42");

    // Async reset mid-cycle with load high
    @(negedge clk);
    bus.a    = 3'd7;
    bus.b    = 3'd7;
    bus.op   = 2'd2;
    bus.load = 1'b1;
    #2 rst = 1'b0;
    exp_q.delete();
    #1;
    show(1'b0);
    check_eq("async_rst_addr0", {bus.sev_seg_1, bus.sev_seg_2}, {7'h3F, 7'h3F});
    show(1'b1);
    check_eq("async_rst_addr1", {bus.sev_seg_1, bus.sev_seg_2}, {7'h3F, 7'h3F});
    @(posedge clk);
    #1;
    check_model("rst_over_load");
    @(negedge clk);
    bus.load = 1'b0;
    rst      = 1'b1;
    drive_load(4, 3, 0);
    check_model("after_rst_load");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
